floor_request_manager: RTL



---
 rtl/floor_request_manager.sv | 109 ++++++++++
 1 files changed

// File: rtl/floor_request_manager.sv
// floor_request_manager: debounces call buttons into a pending-request vector cleared on door service
module floor_request_manager #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2,
  parameter int DB_CYCLES  = 4,
  parameter int CNT_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn_raw,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  door_open,
  output logic [NUM_FLOORS-1:0] req,
  output logic [NUM_FLOORS-1:0] lamp,
  output logic [CNT_W-1:0]      pending_count,
  output logic                  svc_pulse,
  output logic [FLOOR_W-1:0]    served_floor
);
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam logic [1:0] LO_STABLE = 2'd0;
  localparam logic [1:0] CHK_HI    = 2'd1;
  localparam logic [1:0] HI_STABLE = 2'd2;
  localparam logic [1:0] CHK_LO    = 2'd3;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
  logic                  door_open_d;
  logic                  svc_ev;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] clr;
  logic [NUM_FLOORS-1:0] blk;
  logic [NUM_FLOORS-1:0] req_nxt;
  logic [CNT_W-1:0]      cnt_nxt;
  assign svc_ev  = door_open & ~door_open_d;
  assign req_nxt = (req | (press & ~blk)) & ~clr;
  assign lamp    = req;
  genvar i;
  generate
    for (i = 0; i < NUM_FLOORS; i = i + 1) begin : g_btn
      logic [1:0]    sync;
      logic [1:0]    st;
      logic [DW-1:0] cnt;
      logic          deb;
      logic          deb_d;
      assign press[i] = deb & ~deb_d;
      assign blk[i]   = door_open & (current_floor == FLOOR_W'(i));
      assign clr[i]   = svc_ev & (current_floor == FLOOR_W'(i)) & req[i];
      always_ff @(posedge clk) begin
        if (rst) begin
          sync  <= '0;
          st    <= LO_STABLE;
          cnt   <= '0;
          deb   <= 1'b0;
          deb_d <= 1'b0;
        end else begin
          sync  <= {sync[0], btn_raw[i]};
          deb_d <= deb;
          case (st)
            LO_STABLE: if (sync[1]) begin
              st  <= CHK_HI;
              cnt <= DW'(1);
            end
            CHK_HI: if (!sync[1]) begin
              st  <= LO_STABLE;
              cnt <= '0;
            end else if (cnt == DB_LAST) begin
              st  <= HI_STABLE;
              cnt <= '0;
              deb <= 1'b1;
            end else begin
              cnt <= cnt + DW'(1);
            end
            HI_STABLE: if (!sync[1]) begin
              st  <= CHK_LO;
              cnt <= DW'(1);
            end
            default: if (sync[1]) begin
              st  <= HI_STABLE;
              cnt <= '0;
            end else if (cnt == DB_LAST) begin
              st  <= LO_STABLE;
              cnt <= '0;
              deb <= 1'b0;
            end else begin
              cnt <= cnt + DW'(1);
            end
          endcase
        end
      end
    end
  endgenerate
  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < NUM_FLOORS; k++) cnt_nxt = cnt_nxt + CNT_W'(req_nxt[k]);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      door_open_d   <= 1'b0;
      req           <= '0;
      pending_count <= '0;
      svc_pulse     <= 1'b0;
      served_floor  <= '0;
    end else begin
      door_open_d   <= door_open;
      req           <= req_nxt;
      pending_count <= cnt_nxt;
      svc_pulse     <= |clr;
      served_floor  <= |clr ? current_floor : served_floor;
    end
  end
endmodule
